// File: rtl/snake_dir_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : snake_dir_ctrl
// Description : Snake heading controller fed by four debounced button levels.
//               It turns rising button levels into press events and rejects
//               presses that duplicate or reverse the last requested heading.
//               Accepted moves wait in a small FIFO, and one move is applied
//               to the heading on each game step pulse.
//
//               Ports:
//                 clock       - system clock, rising edge
//                 reset       - synchronous, active-high reset
//                 btn_up      - debounced level, 1 = pressed
//                 btn_down    - debounced level, 1 = pressed
//                 btn_left    - debounced level, 1 = pressed
//                 btn_right   - debounced level, 1 = pressed
//                 step        - one-cycle game-step pulse
//                 dir         - current heading (00 up, 01 down, 10 left,
//                               11 right), registered
//                 dir_changed - one-cycle pulse, aligned with a new dir value
//                 q_count     - number of queued moves, registered
//                 overflow    - sticky; an accepted move was dropped because
//                               the queue was full
// Revision    : 1.0 - initial release
// ============================================================================
module snake_dir_ctrl #(
    parameter int         DEPTH    = 2,      // 2 or 4
    parameter logic [1:0] INIT_DIR = 2'b11
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     btn_up,
    input  logic                     btn_down,
    input  logic                     btn_left,
    input  logic                     btn_right,
    input  logic                     step,
    output logic [1:0]               dir,
    output logic                     dir_changed,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     overflow
);

    localparam int              PW     = $clog2(DEPTH);
    localparam int              CW     = PW + 1;
    localparam logic [CW-1:0]   c_FULL = CW'(DEPTH);

    localparam logic [1:0] c_UP    = 2'b00;
    localparam logic [1:0] c_DOWN  = 2'b01;
    localparam logic [1:0] c_LEFT  = 2'b10;
    localparam logic [1:0] c_RIGHT = 2'b11;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [3:0]    r_prev;              // {up, down, left, right}
    logic [1:0]    r_queue [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [1:0]    r_dir;
    logic          r_dir_changed;
    logic          r_overflow;

    // ------------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------------
    logic [3:0]    w_btn;
    logic [3:0]    w_press;
    logic          w_cand_valid;
    logic [1:0]    w_cand;
    logic [PW-1:0] w_last;
    logic [1:0]    w_tail;
    logic          w_reject;
    logic          w_accept;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [CW-1:0] w_count_next;

    assign w_btn   = {btn_up, btn_down, btn_left, btn_right};
    assign w_press = w_btn & ~r_prev;

    // Fixed priority up > down > left > right; losers are simply discarded.
    always_comb begin
        w_cand_valid = 1'b1;
        w_cand       = c_UP;
        if (w_press[3]) begin
            w_cand = c_UP;
        end else if (w_press[2]) begin
            w_cand = c_DOWN;
        end else if (w_press[1]) begin
            w_cand = c_LEFT;
        end else if (w_press[0]) begin
            w_cand = c_RIGHT;
        end else begin
            w_cand_valid = 1'b0;
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);

    // The tail is the newest request: the last queued move, or the live
    // heading once the queue has drained. Pointers wrap naturally because
    // DEPTH is a power of two.
    assign w_last = r_wptr - PW'(1);
    assign w_tail = w_empty ? r_dir : r_queue[w_last];

    // Opposite directions differ only in bit 0.
    assign w_reject = (w_cand == w_tail) || (w_cand == {w_tail[1], ~w_tail[0]});
    assign w_accept = w_cand_valid && !w_reject;

    assign w_pop  = step && !w_empty;
    // A pop in the same cycle frees a slot, so a full queue can still take it.
    assign w_push = w_accept && (!w_full || w_pop);
    assign w_drop = w_accept && w_full && !w_pop;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // ------------------------------------------------------------------------
    // Queue storage (contents are don't-care while pointers are reset)
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_push && !reset) begin
            r_queue[r_wptr] <= w_cand;
        end
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            // Held buttons must be released and pressed again after reset.
            r_prev        <= 4'b1111;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_dir         <= INIT_DIR;
            r_dir_changed <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_prev        <= w_btn;
            r_count       <= w_count_next;
            r_dir_changed <= w_pop;
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_dir  <= r_queue[r_rptr];
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign dir         = r_dir;
    assign dir_changed = r_dir_changed;
    assign q_count     = r_count;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_snake_dir_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_snake_dir_ctrl
// Description : Directed self-checking bench for snake_dir_ctrl (DEPTH=2,
//               INIT_DIR=right). Inputs change 1 time unit after the rising
//               edge; outputs are checked at that same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_dir_ctrl;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          btn_up = 1'b0;
    logic          btn_down = 1'b0;
    logic          btn_left = 1'b0;
    logic          btn_right = 1'b0;
    logic          step = 1'b0;
    logic [1:0]    dir;
    logic          dir_changed;
    logic [CW-1:0] q_count;
    logic          overflow;

    int n_checks = 0;
    int n_fail   = 0;

    snake_dir_ctrl #(
        .DEPTH    (DEPTH),
        .INIT_DIR (2'b11)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .step        (step),
        .dir         (dir),
        .dir_changed (dir_changed),
        .q_count     (q_count),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] e_dir, input logic e_chg,
                             input logic [CW-1:0] e_cnt, input logic e_ovf);
        check({tag, ".dir"},         {2'b00, dir},         {2'b00, e_dir});
        check({tag, ".dir_changed"}, {3'b000, dir_changed}, {3'b000, e_chg});
        check({tag, ".q_count"},     4'(q_count),          4'(e_cnt));
        check({tag, ".overflow"},    {3'b000, overflow},   {3'b000, e_ovf});
    endtask

    // Reset for one cycle, then one idle cycle so prev levels follow the
    // (released) buttons.
    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // One-cycle press: 0=up 1=down 2=left 3=right
    task automatic press(input int b);
        case (b)
            0: btn_up    = 1'b1;
            1: btn_down  = 1'b1;
            2: btn_left  = 1'b1;
            default: btn_right = 1'b1;
        endcase
        tick();
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    endtask

    task automatic do_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    initial begin
        // ---- Reset state ----
        tick();
        tick();
        reset = 1'b0;
        check_all("reset", 2'b11, 1'b0, 2'd0, 1'b0);

        // ---- Button held through reset gives no press ----
        reset  = 1'b1;
        btn_up = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("held_through_reset.q_count", 4'(q_count), 4'd0);
        btn_up = 1'b0;
        tick();
        check("released.q_count", 4'(q_count), 4'd0);
        btn_up = 1'b1;
        tick();
        check("repress.q_count", 4'(q_count), 4'd1);
        btn_up = 1'b0;

        // ---- Step five cycles later applies up ----
        repeat (4) tick();
        check_all("before_step", 2'b11, 1'b0, 2'd1, 1'b0);
        do_step();
        check_all("after_step", 2'b00, 1'b1, 2'd0, 1'b0);
        tick();
        check("pulse_one_cycle.dir_changed", {3'b000, dir_changed}, 4'd0);

        // ---- Reversal and duplicate rejected ----
        do_reset();
        press(2);                       // left reverses right
        check("reversal.q_count", 4'(q_count), 4'd0);
        press(3);                       // right duplicates right
        check_all("duplicate", 2'b11, 1'b0, 2'd0, 1'b0);
        do_step();
        check_all("empty_step", 2'b11, 1'b0, 2'd0, 1'b0);

        // ---- Up then left between steps ----
        press(0);
        press(2);
        check("two_moves.q_count", 4'(q_count), 4'd2);
        do_step();
        check_all("two_moves.step1", 2'b00, 1'b1, 2'd1, 1'b0);
        tick();
        check("two_moves.gap.dir_changed", {3'b000, dir_changed}, 4'd0);
        do_step();
        check_all("two_moves.step2", 2'b10, 1'b1, 2'd0, 1'b0);

        // ---- Full queue drops an accepted move ----
        do_reset();
        press(0);
        press(2);
        check_all("full_before_down", 2'b11, 1'b0, 2'd2, 1'b0);
        press(1);                       // down vs tail left: accepted, dropped
        check_all("overflow", 2'b11, 1'b0, 2'd2, 1'b1);
        do_step();
        check_all("overflow_sticky", 2'b00, 1'b1, 2'd1, 1'b1);

        // ---- Full queue with simultaneous pop accepts ----
        do_reset();
        press(0);
        press(2);
        btn_down = 1'b1;
        step     = 1'b1;
        tick();
        btn_down = 1'b0;
        step     = 1'b0;
        check_all("push_pop_full", 2'b00, 1'b1, 2'd2, 1'b0);
        do_step();
        check_all("push_pop_full.step2", 2'b10, 1'b1, 2'd1, 1'b0);
        do_step();
        check_all("push_pop_full.step3", 2'b01, 1'b1, 2'd0, 1'b0);

        // ---- q_count==1 push/pop: tail is the entry being popped ----
        do_reset();
        press(0);                       // queue: up
        btn_down = 1'b1;                // reverses tail=up -> rejected
        step     = 1'b1;
        tick();
        btn_down = 1'b0;
        step     = 1'b0;
        check_all("one_entry_reversal", 2'b00, 1'b1, 2'd0, 1'b0);
        press(2);                       // queue: left
        btn_right = 1'b1;               // right vs tail left: rejected
        step      = 1'b1;
        tick();
        btn_right = 1'b0;
        step      = 1'b0;
        check_all("one_entry_reject2", 2'b10, 1'b1, 2'd0, 1'b0);
        press(0);                       // up vs left: queued
        btn_left = 1'b1;                // left vs tail up: accepted alongside pop
        step     = 1'b1;
        tick();
        btn_left = 1'b0;
        step     = 1'b0;
        check_all("one_entry_accept", 2'b00, 1'b1, 2'd1, 1'b0);

        // ---- Simultaneous up+left: only up queued; reset flushes ----
        do_reset();
        btn_up   = 1'b1;
        btn_left = 1'b1;
        tick();
        btn_up   = 1'b0;
        btn_left = 1'b0;
        check("simul.q_count", 4'(q_count), 4'd1);
        reset = 1'b1;
        step  = 1'b1;                   // ignored during reset
        tick();
        reset = 1'b0;
        step  = 1'b0;
        check_all("flush", 2'b11, 1'b0, 2'd0, 1'b0);
        do_step();
        check_all("flush_step", 2'b11, 1'b0, 2'd0, 1'b0);

        // ---- down+left simultaneous with dir=right: down wins ----
        btn_down = 1'b1;
        btn_left = 1'b1;
        tick();
        btn_down = 1'b0;
        btn_left = 1'b0;
        do_step();
        check_all("down_priority", 2'b01, 1'b1, 2'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
Direction controller directly downstream of the four button debounce filters. It turns the filtered button levels into press events and rejects illegal moves: duplicates and 180-degree reversals. Accepted moves are buffered in a small FIFO, and one move is applied to the snake heading per game step pulse. This keeps fast double-taps (e.g. up then left within one step) from being lost or causing self-collision.

Parameters:
DEPTH, 2, move-queue depth; power of two, legal values 2 or 4.
INIT_DIR, 2'b11, heading after reset. Encoding: 00 up, 01 down, 10 left, 11 right.

Ports:
clock  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous, active-high reset.
btn_up  input  1  debounced level, 1 = pressed.
btn_down  input  1  debounced level.
btn_left  input  1  debounced level.
btn_right  input  1  debounced level.
step  input  1  one-cycle pulse from the game timer; the snake advances this cycle.
dir  output  2  current heading, registered.
dir_changed  output  1  one-cycle pulse, high in the cycle dir takes a new value.
q_count  output  $clog2(DEPTH)+1  number of queued moves, registered.
overflow  output  1  sticky; set when an accepted move is dropped because the queue is full.

Behaviour:
- Reset (synchronous, sampled on clock edge):
  - dir = INIT_DIR; dir_changed = 0; q_count = 0; overflow = 0.
  - Queue pointers are cleared.
  - The four previous-level registers are set to 1, so a button held through reset produces no press until it is released and pressed again.
- Reset mid-operation flushes all queued moves immediately; step in the reset cycle is ignored.
- Press detect: press_x = btn_x & ~prev_x. prev_x <= btn_x every cycle.
- Simultaneous presses in one cycle:
  - Priority is up > down > left > right.
  - Only the winning press is considered; the others are discarded and not retried.
- Reference heading (tail):
  - tail = most recently queued entry if q_count != 0, else dir.
  - tail is always evaluated on pre-cycle state.
- Candidate rejection:
  - Rejected if candidate == tail (duplicate).
  - Rejected if candidate == {tail[1], ~tail[0]} (reversal).
  - Rejected candidates have no effect, including on overflow.
- Push:
  - An accepted candidate is written at the write pointer and q_count increments.
  - Visible in q_count the cycle after the press cycle.
- Pop: when step = 1 and q_count != 0:
  - dir <= head entry; read pointer advances; q_count decrements.
  - dir_changed = 1 in the following cycle only, aligned with the new dir.
- step with empty queue: dir holds and dir_changed stays 0. The controller does not track whether the snake moved.
- Simultaneous push and pop in the same cycle:
  - Both occur and q_count is unchanged.
  - When full, the pop frees space, so the push is accepted with no overflow.
  - Case q_count == 1: tail is the popped entry; the new entry is checked against it.
- Full without pop: an accepted candidate is dropped and overflow <= 1. overflow clears only on reset.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. q_count saturates logically at DEPTH; it never exceeds DEPTH or underflows.
- Latency: press to q_count update is 1 cycle; step to dir update is 1 cycle. Press and step in the same cycle with an empty queue: the move is queued and applied on the next step, not this one.

Test Plan:
- Reset with INIT_DIR=11 and all buttons 0 -> dir=11, q_count=0, overflow=0, dir_changed=0. Hold btn_up=1 through reset release -> no push until btn_up falls and rises again.
- dir=11, pulse btn_up rise, then step 5 cycles later -> q_count=1 one cycle after the press; dir=00 and dir_changed=1 exactly one cycle after step; q_count=0 after.
- dir=11, press btn_left (reversal), then btn_right (duplicate) -> q_count stays 0, overflow stays 0; a step gives no change.
- dir=11, press up then left between steps, then two steps -> q_count=2; dir goes 00 after the first step, then 10 after the second; two dir_changed pulses.
- DEPTH=2, dir=11, press up, left, down with no step -> down is checked against tail=10 and accepted but the queue is full: dropped, overflow=1, q_count=2. Repeat with step coinciding with the down press -> accepted, q_count=2, overflow=0.
- btn_up and btn_left rise in the same cycle, dir=11 -> only up is queued (q_count=1); reset asserted next cycle -> q_count=0, dir=11.
